uart_tx_scheduler: RTL and testbench

Owns the single UART TX byte stream and shares it between two requesters: the UART RX echo path (single bytes) and the accelerometer sample stream (64-bit beats). Accelerometer samples are optionally decimated, buffered one-deep and serialized into fixed 11-byte frames. Arbitration is round-robin at frame/byte boundaries. The block sits between the adxl345 data stream, the UART RX stream and the UART TX stream.

---
 rtl/uart_sched_pkg.sv | 22 ++
 rtl/uart_tx_scheduler_if.sv | 34 +++
 rtl/uart_tx_scheduler_decimator.sv | 47 ++++
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and constants for the UART TX scheduler
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ECHO,
      ST_SEQ,
      ST_DATA,
      ST_CSUM
   } sched_state_t;

   typedef enum logic {
      GRANT_ECHO,
      GRANT_ACCEL
   } grant_t;

   // Bytes per frame beyond the payload: sync, seq, csum.
   localparam int FRAME_OVERHEAD = 3;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - accel, echo and TX streams of the UART TX scheduler
interface uart_tx_scheduler_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] s_accel_tdata;
   logic                  s_accel_tvalid;
   logic                  s_accel_tready;
   logic [7:0]            s_echo_tdata;
   logic                  s_echo_tvalid;
   logic                  s_echo_tready;
   logic [7:0]            m_tx_tdata;
   logic                  m_tx_tvalid;
   logic                  m_tx_tready;

   // Environment side: sources accel/echo beats, sinks TX bytes.
   modport master (
      output s_accel_tdata, s_accel_tvalid,
      input  s_accel_tready,
      output s_echo_tdata, s_echo_tvalid,
      input  s_echo_tready,
      input  m_tx_tdata, m_tx_tvalid,
      output m_tx_tready
   );

   // Scheduler side.
   modport slave (
      input  s_accel_tdata, s_accel_tvalid,
      output s_accel_tready,
      input  s_echo_tdata, s_echo_tvalid,
      output s_echo_tready,
      output m_tx_tdata, m_tx_tvalid,
      input  m_tx_tready
   );
endinterface

// File: rtl/uart_tx_scheduler_decimator.sv
// rtl/uart_tx_scheduler_decimator.sv - sample decimation, one-deep buffer and drop counter
module accel_sample_decimator #(
   parameter int DATA_WIDTH = 64,
   parameter int DECIMATE   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] beat_tdata,
   input  logic                  beat_valid,
   input  logic                  take,
   output logic [DATA_WIDTH-1:0] buf_data,
   output logic                  buf_valid,
   output logic [15:0]           dropped_count
);

   logic [15:0] decim_cnt;
   logic        keep;

   assign keep = beat_valid && (decim_cnt == 16'd0);

   // Count accepted beats modulo DECIMATE; hold the newest kept beat until the scheduler takes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         decim_cnt     <= 16'd0;
         buf_data      <= '0;
         buf_valid     <= 1'b0;
         dropped_count <= 16'd0;
      end else begin
         if (beat_valid) begin
            if (decim_cnt == 16'(DECIMATE - 1))
               decim_cnt <= 16'd0;
            else
               decim_cnt <= decim_cnt + 16'd1;
         end
         if (keep) begin
            buf_data  <= beat_tdata;
            buf_valid <= 1'b1;
            // A beat landing in the same cycle the old one is taken is not a loss.
            if (buf_valid && !take && dropped_count != 16'hFFFF)
               dropped_count <= dropped_count + 16'd1;
         end else if (take) begin
            buf_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares the UART TX byte stream between echo bytes and accel frames
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int         DATA_WIDTH = 64,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
   parameter int         DECIMATE   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_tx_scheduler_if.slave   bus,
   output logic [15:0]          dropped_count,
   output logic                 busy
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   sched_state_t          state;
   grant_t                last_grant;
   logic [7:0]            seq;
   logic [7:0]            csum;
   logic [7:0]            tx_tdata;
   logic                  tx_tvalid;
   logic                  accel_ready;
   logic                  csum_pending;
   logic [DATA_WIDTH-1:0] shreg;
   logic [IDX_W-1:0]      byte_idx;
   logic [DATA_WIDTH-1:0] buf_data;
   logic                  buf_valid;
   logic                  slot_free;
   logic                  pick_accel;
   logic                  take;
   logic                  echo_grant;

   assign slot_free          = !tx_tvalid || bus.m_tx_tready;
   assign bus.m_tx_tdata     = tx_tdata;
   assign bus.m_tx_tvalid    = tx_tvalid;
   assign bus.s_accel_tready = accel_ready;
   assign bus.s_echo_tready  = (state == ST_ECHO) && slot_free;
   assign busy               = (state != ST_IDLE);

   // Round-robin choice between a buffered sample and a waiting echo byte.
   always_comb begin
      pick_accel = buf_valid;
      if (buf_valid && bus.s_echo_tvalid)
         pick_accel = (last_grant == GRANT_ECHO);
   end

   assign take       = (state == ST_IDLE) && slot_free && pick_accel;
   assign echo_grant = (state == ST_IDLE) && slot_free && !pick_accel && bus.s_echo_tvalid;

   accel_sample_decimator #(
      .DATA_WIDTH (DATA_WIDTH),
      .DECIMATE   (DECIMATE)
   ) u_decim (
      .clk           (clk),
      .reset         (reset),
      .beat_tdata    (bus.s_accel_tdata),
      .beat_valid    (bus.s_accel_tvalid && accel_ready),
      .take          (take),
      .buf_data      (buf_data),
      .buf_valid     (buf_valid),
      .dropped_count (dropped_count)
   );

   // Arbitration, frame serialization and the single TX output slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         last_grant   <= GRANT_ECHO;
         seq          <= 8'd0;
         csum         <= 8'd0;
         tx_tdata     <= 8'd0;
         tx_tvalid    <= 1'b0;
         accel_ready  <= 1'b0;
         csum_pending <= 1'b0;
         shreg        <= '0;
         byte_idx     <= '0;
      end else begin
         accel_ready <= 1'b1;
         if (tx_tvalid && bus.m_tx_tready) begin
            tx_tvalid <= 1'b0;
            if (csum_pending) begin
               seq          <= seq + 8'd1;
               csum_pending <= 1'b0;
            end
         end
         case (state)
            ST_IDLE: begin
               if (take) begin
                  tx_tdata   <= SYNC_BYTE;
                  tx_tvalid  <= 1'b1;
                  shreg      <= buf_data;
                  last_grant <= GRANT_ACCEL;
                  state      <= ST_SEQ;
               end else if (echo_grant) begin
                  last_grant <= GRANT_ECHO;
                  state      <= ST_ECHO;
               end
            end
            ST_ECHO: begin
               if (bus.s_echo_tvalid && slot_free) begin
                  tx_tdata  <= bus.s_echo_tdata;
                  tx_tvalid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_SEQ: begin
               // The previous frame's seq increment must land before this seq byte goes out.
               if (slot_free && !csum_pending) begin
                  tx_tdata  <= seq;
                  tx_tvalid <= 1'b1;
                  csum      <= seq;
                  byte_idx  <= '0;
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (slot_free) begin
                  tx_tdata  <= shreg[7:0];
                  tx_tvalid <= 1'b1;
                  csum      <= csum + shreg[7:0];
                  shreg     <= shreg >> 8;
                  byte_idx  <= byte_idx + 1'b1;
                  if (byte_idx == IDX_W'(NBYTES - 1))
                     state <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (slot_free) begin
                  tx_tdata     <= csum;
                  tx_tvalid    <= 1'b1;
                  csum_pending <= 1'b1;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - scoreboard bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
   import uart_sched_pkg::*;

   localparam int NB = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] a_tdata = '0;
   logic        a_tvalid = 1'b0;
   logic [7:0]  e_tdata = '0;
   logic        e_tvalid = 1'b0;
   logic        tx_ready = 1'b1;
   logic        rand_ready = 1'b0;
   logic        sel4 = 1'b0;

   uart_tx_scheduler_if #(.DATA_WIDTH(64)) bus1 ();
   uart_tx_scheduler_if #(.DATA_WIDTH(64)) bus4 ();

   assign bus1.s_accel_tdata  = a_tdata;
   assign bus1.s_accel_tvalid = a_tvalid;
   assign bus1.s_echo_tdata   = e_tdata;
   assign bus1.s_echo_tvalid  = e_tvalid;
   assign bus1.m_tx_tready    = tx_ready;
   assign bus4.s_accel_tdata  = a_tdata;
   assign bus4.s_accel_tvalid = a_tvalid;
   assign bus4.s_echo_tdata   = e_tdata;
   assign bus4.s_echo_tvalid  = e_tvalid;
   assign bus4.m_tx_tready    = tx_ready;

   logic [15:0] drop1, drop4;
   logic        busy1, busy4;

   uart_tx_scheduler #(.DATA_WIDTH(64), .SYNC_BYTE(8'hA5), .DECIMATE(1)) dut (
      .clk(clk), .reset(reset), .bus(bus1), .dropped_count(drop1), .busy(busy1));

   uart_tx_scheduler #(.DATA_WIDTH(64), .SYNC_BYTE(8'hA5), .DECIMATE(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4), .dropped_count(drop4), .busy(busy4));

   logic [7:0]  mon_tdata;
   logic        mon_tvalid, mon_echo_ready, mon_accel_ready, mon_busy;
   logic [15:0] mon_dropped;

   always_comb begin
      if (sel4) begin
         mon_tdata = bus4.m_tx_tdata;  mon_tvalid = bus4.m_tx_tvalid;
         mon_echo_ready = bus4.s_echo_tready; mon_accel_ready = bus4.s_accel_tready;
         mon_busy = busy4; mon_dropped = drop4;
      end else begin
         mon_tdata = bus1.m_tx_tdata;  mon_tvalid = bus1.m_tx_tvalid;
         mon_echo_ready = bus1.s_echo_tready; mon_accel_ready = bus1.s_accel_tready;
         mon_busy = busy1; mon_dropped = drop1;
      end
   end

   int n_checks = 0;
   int n_fails  = 0;
   int hs_count = 0;
   logic [7:0] exp_q[$];
   logic       stall_prev = 1'b0;
   logic [7:0] held = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            check_eq("stall_valid", mon_tvalid, 1);
            check_eq("stall_data", mon_tdata, held);
         end
         if (mon_tvalid && tx_ready) begin
            hs_count <= hs_count + 1;
            if (exp_q.size() == 0)
               check_eq("tx_expected_pending", exp_q.size(), 1);
            else
               check_eq("tx_byte", mon_tdata, exp_q.pop_front());
         end
         stall_prev <= mon_tvalid && !tx_ready;
         held       <= mon_tdata;
      end
   end

   task automatic push_frame(input logic [7:0] s, input logic [63:0] d);
      logic [7:0] cs;
      cs = s;
      exp_q.push_back(8'hA5);
      exp_q.push_back(s);
      for (int i = 0; i < NB; i++) begin
         exp_q.push_back(d[8*i +: 8]);
         cs = cs + d[8*i +: 8];
      end
      exp_q.push_back(cs);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      a_tvalid = 1'b0;
      e_tvalid = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [63:0] d);
      a_tdata  = d;
      a_tvalid = 1'b1;
      @(posedge clk);
      #1 a_tvalid = 1'b0;
   endtask

   task automatic wait_echo();
      int waited;
      waited = 0;
      @(negedge clk);
      while (!mon_echo_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check_eq("echo_accepted", mon_echo_ready, 1);
      @(posedge clk);
      #1 e_tvalid = 1'b0;
   endtask

   task automatic send_echo(input logic [7:0] b);
      e_tdata  = b;
      e_tvalid = 1'b1;
      wait_echo();
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      check_eq("drain_empty", exp_q.size(), 0);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int base;
      int waited;

      // Reset values, sampled while reset is held.
      @(negedge clk);
      check_eq("rst_tvalid", mon_tvalid, 0);
      check_eq("rst_tdata", mon_tdata, 0);
      check_eq("rst_accel_ready", mon_accel_ready, 0);
      check_eq("rst_echo_ready", mon_echo_ready, 0);
      do_reset();
      check_eq("post_rst_accel_ready", mon_accel_ready, 1);
      check_eq("post_rst_dropped", mon_dropped, 0);
      check_eq("post_rst_busy", mon_busy, 0);

      // Single frame, first-byte latency and busy.
      push_frame(8'h00, 64'h0807060504030201);
      send_beat(64'h0807060504030201);
      check_eq("latency_not_yet", mon_tvalid, 0);
      @(posedge clk);
      #1;
      check_eq("latency_tvalid", mon_tvalid, 1);
      check_eq("latency_sync", mon_tdata, 8'hA5);
      check_eq("busy_in_frame", mon_busy, 1);
      drain();
      check_eq("busy_after_frame", mon_busy, 0);

      // Same frame under random backpressure.
      do_reset();
      rand_ready = 1'b1;
      push_frame(8'h00, 64'h0807060504030201);
      send_beat(64'h0807060504030201);
      drain();
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Echo and accel contending.
      do_reset();
      push_frame(8'h00, 64'hDEADBEEF01234567);
      exp_q.push_back(8'h55);
      send_beat(64'hDEADBEEF01234567);
      send_echo(8'h55);
      drain();
      exp_q.push_back(8'h55);
      push_frame(8'h01, 64'h0F1E2D3C4B5A6978);
      a_tdata  = 64'h0F1E2D3C4B5A6978;
      a_tvalid = 1'b1;
      e_tdata  = 8'h55;
      e_tvalid = 1'b1;
      @(posedge clk);
      #1 a_tvalid = 1'b0;
      wait_echo();
      drain();

      // Overwrite of a buffered beat while a frame is in flight.
      do_reset();
      push_frame(8'h00, 64'h1122334455667788);
      push_frame(8'h01, 64'hC0C1C2C3C4C5C6C7);
      send_beat(64'h1122334455667788);
      repeat (2) @(posedge clk);
      #1;
      send_beat(64'hB0B1B2B3B4B5B6B7);
      repeat (2) @(posedge clk);
      #1;
      send_beat(64'hC0C1C2C3C4C5C6C7);
      drain();
      check_eq("dropped_one", mon_dropped, 1);

      // Decimation by four.
      sel4 = 1'b1;
      do_reset();
      push_frame(8'h00, 64'h0);
      push_frame(8'h01, 64'h0404040404040404);
      for (int i = 0; i < 8; i++) begin
         a_tdata  = 64'h0101010101010101 * 64'(i);
         a_tvalid = 1'b1;
         @(negedge clk);
         check_eq("dec4_accel_ready", mon_accel_ready, 1);
         @(posedge clk);
         #1;
      end
      a_tvalid = 1'b0;
      drain();
      check_eq("dec4_dropped", mon_dropped, 0);
      sel4 = 1'b0;

      // Reset in the middle of a frame, then seq restart and wrap.
      do_reset();
      push_frame(8'h00, 64'hA1A2A3A4A5A6A7A8);
      base = hs_count;
      send_beat(64'hA1A2A3A4A5A6A7A8);
      waited = 0;
      while (hs_count < base + 5 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check_eq("reached_data3", hs_count >= base + 5, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check_eq("midframe_rst_tvalid", mon_tvalid, 0);
      check_eq("midframe_rst_busy", mon_busy, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      d = 64'h0123456789ABCDEF;
      push_frame(8'h00, d);
      send_beat(d);
      drain();
      for (int k = 1; k <= 256; k++) begin
         d = {$urandom, $urandom};
         push_frame(8'(k), d);
         send_beat(d);
         drain();
      end
      check_eq("final_dropped", mon_dropped, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
